// File: rtl/parity_seq_ctrl.sv
// parity_seq_ctrl: serial parity generator.
// A WIDTH-bit word is accepted over a valid/ready handshake, folded one bit
// per clock into a single XOR accumulator, and offered downstream together
// with its parity bit. The downstream side is also valid/ready, and the next
// word can be loaded on the same edge that retires the current result.
// Optional build macro PARITY_CHECK_EN adds a received-parity input. It also
// adds a mismatch flag and a saturating mismatch counter.
module parity_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter bit ODD   = 1'b0,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef PARITY_CHECK_EN
    input  logic             in_parity,
    output logic             out_err,
    output logic [7:0]       err_cnt,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic [WIDTH-1:0] shreg;
    logic             load;
    logic             last_bit;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode, intake handshake and shift control.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A new word is only taken when the current result leaves.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter and XOR accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= 1'b0;
            shreg <= '0;
        end else if (load) begin
            cnt   <= '0;
            acc   <= 1'b0;
            shreg <= in_data;
        end else if (state == SHIFT) begin
            acc   <= acc ^ shreg[0];
            shreg <= shreg >> 1;
            // Hold at the last index instead of wrapping.
            if (!last_bit) cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered result outputs; parity is captured as the last bit folds in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            out_parity <= ODD;
        end else begin
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            if (load)     out_data   <= in_data;
            if (last_bit) out_parity <= acc ^ shreg[0] ^ ODD;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_cap;

    // Received-parity compare and saturating mismatch count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_cap <= 1'b0;
            out_err <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            if (load) par_cap <= in_parity;
            if (last_bit)                    out_err <= ((acc ^ shreg[0] ^ ODD) != par_cap);
            else if (out_valid && out_ready) out_err <= 1'b0;
            if (out_valid && out_ready && out_err && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule
